// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback signals of the load/store unit.
// The master side is the execute stage, data memory and writeback stage together.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        busy;
    logic        fault;
    logic [15:0] fault_addr;
    logic [7:0]  fault_count;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_rd, mem_rdata, wb_ready,
        input  req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
               wb_valid, wb_data, wb_rd, busy, fault, fault_addr, fault_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_rd, mem_rdata, wb_ready,
        output req_ready, mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
               wb_valid, wb_data, wb_rd, busy, fault, fault_addr, fault_count
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a sync-write, async-read data memory.
// Range-checks each request, drives registered memory strobes and returns load data to writeback.
module load_store_unit #(
    parameter int unsigned MEM_DEPTH   = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;
    localparam logic [1:0]  ST_FAULT  = 2'd3;
    localparam logic [16:0] DEPTH     = 17'(MEM_DEPTH);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

    logic [1:0]  state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic        we_q, we_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic [15:0] faddr_q, faddr_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        in_range;

    assign in_range = {1'b0, bus.req_addr} < DEPTH;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        we_d      = we_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        faddr_d   = faddr_q;
        fcnt_d    = fcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    rd_d    = bus.req_rd;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (in_range) begin
                        state_d = ST_ACCESS;
                        wait_d  = WAIT_INIT;
                        rd_en_d = !bus.req_we;
                        wr_en_d = bus.req_we && (WAIT_INIT == 3'd0);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_ACCESS: begin
                // Strobes are registered, so the write enable is raised one edge
                // ahead of the cycle in which wait_cnt reaches zero.
                if (wait_q != 3'd0) begin
                    wait_d  = wait_q - 3'd1;
                    rd_en_d = !we_q;
                    wr_en_d = we_q && (wait_q == 3'd1);
                end else if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    wb_data_d = bus.mem_rdata;
                    wb_rd_d   = rd_q;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.wb_ready) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                faddr_d = addr_q;
                if (fcnt_q != 8'hFF) fcnt_d = fcnt_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wait_q    <= 3'd0;
            we_q      <= 1'b0;
            rd_q      <= 3'd0;
            addr_q    <= 16'h0;
            wdata_q   <= 16'h0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wb_data_q <= 16'h0;
            wb_rd_q   <= 3'd0;
            faddr_q   <= 16'h0;
            fcnt_q    <= 8'h0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            faddr_q   <= faddr_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.wb_valid    = (state_q == ST_RESP);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.fault_addr  = faddr_q;
    assign bus.fault_count = fcnt_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with no wait states, one with two,
// each backed by a 10-word memory and checked against a transaction-level model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if b0();
    load_store_unit_if b2();

    load_store_unit #(.MEM_DEPTH(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    load_store_unit #(.MEM_DEPTH(10), .WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    logic [15:0] mem0 [0:9] = '{16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4004,
                                16'h4005, 16'h4006, 16'h4007, 16'h4008, 16'h4009};
    logic [15:0] mem2 [0:9] = '{16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4004,
                                16'h4005, 16'h4006, 16'h4007, 16'h4008, 16'h4009};

    assign b0.mem_rdata = (b0.mem_addr < 16'd10) ? mem0[b0.mem_addr[3:0]] : 16'h0;
    assign b2.mem_rdata = (b2.mem_addr < 16'd10) ? mem2[b2.mem_addr[3:0]] : 16'h0;

    int wr0_cnt = 0, rd0_cnt = 0, flt0_cnt = 0, wr2_cnt = 0, rd2_cnt = 0;
    int both_cnt = 0, fstrobe_cnt = 0;

    always @(posedge clk) begin
        if (b0.mem_wr_en && b0.mem_addr < 16'd10) mem0[b0.mem_addr[3:0]] <= b0.mem_wdata;
        if (b2.mem_wr_en && b2.mem_addr < 16'd10) mem2[b2.mem_addr[3:0]] <= b2.mem_wdata;
        if (b0.mem_wr_en) wr0_cnt <= wr0_cnt + 1;
        if (b0.mem_rd_en) rd0_cnt <= rd0_cnt + 1;
        if (b0.fault) flt0_cnt <= flt0_cnt + 1;
        if (b2.mem_wr_en) wr2_cnt <= wr2_cnt + 1;
        if (b2.mem_rd_en) rd2_cnt <= rd2_cnt + 1;
        if ((b0.mem_wr_en && b0.mem_rd_en) || (b2.mem_wr_en && b2.mem_rd_en)) both_cnt <= both_cnt + 1;
        if (b0.fault && (b0.mem_wr_en || b0.mem_rd_en || b0.wb_valid)) fstrobe_cnt <= fstrobe_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] ref0 [0:9];
    logic [7:0]  m_fcnt;
    logic [15:0] m_faddr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one request on the W=0 instance and reports what was observed.
    task automatic run_op0(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [2:0] rd, input int hold, input logic keep,
                           output int lat, output logic [15:0] data, output logic [2:0] tag,
                           output int nwr, output int nrd, output int nflt, output logic stable);
        int wr_s, rd_s, f_s, guard;
        wr_s = wr0_cnt; rd_s = rd0_cnt; f_s = flt0_cnt;
        b0.wb_ready = 1'b0;
        b0.req_we = we; b0.req_addr = addr; b0.req_wdata = wdata; b0.req_rd = rd;
        b0.req_valid = 1'b1;
        guard = 0;
        while (!b0.req_ready && guard < 30) begin step(); guard++; end
        step();
        b0.req_valid = keep;
        b0.req_we = 1'b1; b0.req_addr = 16'h0; b0.req_wdata = wdata ^ 16'h5A5A; b0.req_rd = ~rd;
        lat = 1; stable = 1'b1;
        while (!b0.wb_valid && !b0.req_ready && lat < 30) begin step(); lat++; end
        data = b0.wb_data; tag = b0.wb_rd;
        if (b0.wb_valid) begin
            for (int i = 0; i < hold; i++) begin
                step();
                if (b0.wb_valid !== 1'b1 || b0.wb_data !== data || b0.wb_rd !== tag ||
                    b0.req_ready !== 1'b0) stable = 1'b0;
            end
            b0.wb_ready = 1'b1;
            step();
            if (b0.wb_valid !== 1'b0 || b0.req_ready !== 1'b1) stable = 1'b0;
            b0.wb_ready = 1'b0;
        end
        b0.req_valid = 1'b0;
        nwr = wr0_cnt - wr_s; nrd = rd0_cnt - rd_s; nflt = flt0_cnt - f_s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_vec++;
        if ({b0.req_ready, b0.wb_valid, b0.fault, b0.mem_wr_en, b0.mem_rd_en, b0.busy} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl0: got %b want 100000",
                     {b0.req_ready, b0.wb_valid, b0.fault, b0.mem_wr_en, b0.mem_rd_en, b0.busy});
        end
        n_vec++;
        if ({b2.req_ready, b2.wb_valid, b2.fault, b2.mem_wr_en, b2.mem_rd_en, b2.busy} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl2: got %b want 100000",
                     {b2.req_ready, b2.wb_valid, b2.fault, b2.mem_wr_en, b2.mem_rd_en, b2.busy});
        end
        rst = 1'b0;
        step();
        n_vec++;
        if ({b0.fault_count, b0.fault_addr, b0.wb_data, b0.wb_rd, b0.mem_addr, b0.mem_wdata} !== 75'h0) begin
            n_err++;
            $display("FAIL reset_data0: cnt=%0h faddr=%0h wbd=%0h wbrd=%0h maddr=%0h mwd=%0h want all 0",
                     b0.fault_count, b0.fault_addr, b0.wb_data, b0.wb_rd, b0.mem_addr, b0.mem_wdata);
        end
        n_vec++;
        if (b0.req_ready !== 1'b1 || b0.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready=%b busy=%b want 1 0", b0.req_ready, b0.busy);
        end
    endtask

    task automatic test_load_basic();
        int lat, nwr, nrd, nflt; logic [15:0] d; logic [2:0] t; logic st;
        run_op0(1'b0, 16'd3, 16'h1111, 3'd5, 0, 1'b0, lat, d, t, nwr, nrd, nflt, st);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL load3_latency: got %0d want 2", lat); end
        n_vec++;
        if (d !== 16'h4003 || t !== 3'd5) begin
            n_err++; $display("FAIL load3_data: got %h/%0d want 4003/5", d, t);
        end
        n_vec++;
        if (nrd !== 1 || nwr !== 0 || nflt !== 0 || st !== 1'b1) begin
            n_err++; $display("FAIL load3_strobes: rd=%0d wr=%0d flt=%0d stable=%b want 1 0 0 1", nrd, nwr, nflt, st);
        end
    endtask

    task automatic test_store_load();
        int lat, nwr, nrd, nflt; logic [15:0] d; logic [2:0] t; logic st;
        run_op0(1'b1, 16'd9, 16'hBEEF, 3'd1, 0, 1'b1, lat, d, t, nwr, nrd, nflt, st);
        ref0[9] = 16'hBEEF;
        n_vec++;
        if (lat !== 2 || nwr !== 1 || nrd !== 0 || nflt !== 0) begin
            n_err++; $display("FAIL store9: lat=%0d wr=%0d rd=%0d flt=%0d want 2 1 0 0", lat, nwr, nrd, nflt);
        end
        step(); step();
        n_vec++;
        if (b0.mem_addr !== 16'd9 || b0.mem_wdata !== 16'hBEEF) begin
            n_err++; $display("FAIL store9_hold: addr=%h wdata=%h want 0009 beef", b0.mem_addr, b0.mem_wdata);
        end
        run_op0(1'b0, 16'd9, 16'h0, 3'd2, 1, 1'b0, lat, d, t, nwr, nrd, nflt, st);
        n_vec++;
        if (d !== 16'hBEEF || t !== 3'd2 || lat !== 2 || nwr !== 0) begin
            n_err++; $display("FAIL load9: data=%h tag=%0d lat=%0d wr=%0d want beef 2 2 0", d, t, lat, nwr);
        end
    endtask

    task automatic test_fault();
        int lat, nwr, nrd, nflt; logic [15:0] d; logic [2:0] t; logic st;
        run_op0(1'b0, 16'd10, 16'h0, 3'd3, 0, 1'b0, lat, d, t, nwr, nrd, nflt, st);
        m_fcnt = 8'd1; m_faddr = 16'd10;
        n_vec++;
        if (nflt !== 1 || nwr !== 0 || nrd !== 0 || lat !== 2 || b0.fault_addr !== 16'd10) begin
            n_err++;
            $display("FAIL fault10: flt=%0d wr=%0d rd=%0d lat=%0d faddr=%h want 1 0 0 2 000a",
                     nflt, nwr, nrd, lat, b0.fault_addr);
        end
        run_op0(1'b1, 16'hFFFF, 16'h1234, 3'd0, 0, 1'b1, lat, d, t, nwr, nrd, nflt, st);
        m_fcnt = 8'd2; m_faddr = 16'hFFFF;
        n_vec++;
        if (nflt !== 1 || nwr !== 0 || b0.fault_addr !== m_faddr || b0.fault_count !== m_fcnt) begin
            n_err++;
            $display("FAIL faultFFFF: flt=%0d wr=%0d faddr=%h cnt=%0d want 1 0 ffff 2",
                     nflt, nwr, b0.fault_addr, b0.fault_count);
        end
    endtask

    task automatic test_fault_saturate();
        int lat, nwr, nrd, nflt, total; logic [15:0] d, a; logic [2:0] t; logic st;
        total = 0;
        for (int i = 0; i < 258; i++) begin
            a = 16'($urandom_range(10, 65535));
            run_op0(1'($urandom_range(0, 1)), a, 16'h0, 3'd0, 0, 1'b0, lat, d, t, nwr, nrd, nflt, st);
            total += nflt;
            if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
            m_faddr = a;
            if (m_fcnt == 8'hFE && i < 253) begin
                n_vec++;
                if (b0.fault_count !== 8'hFE) begin
                    n_err++; $display("FAIL fault_cnt_254: got %0d want 254", b0.fault_count);
                end
            end
        end
        n_vec++;
        if (b0.fault_count !== 8'hFF || b0.fault_addr !== m_faddr) begin
            n_err++; $display("FAIL fault_saturate: cnt=%0h faddr=%h want ff %h", b0.fault_count, b0.fault_addr, m_faddr);
        end
        n_vec++;
        if (total !== 258) begin n_err++; $display("FAIL fault_pulses: got %0d want 258", total); end
    endtask

    task automatic test_wait_states();
        int lat, rd_s, wr_s; logic [15:0] d; logic [2:0] t; logic st;
        rd_s = rd2_cnt;
        b2.wb_ready = 1'b0;
        b2.req_we = 1'b0; b2.req_addr = 16'd5; b2.req_wdata = 16'h0; b2.req_rd = 3'd6; b2.req_valid = 1'b1;
        step();
        b2.req_valid = 1'b0; b2.req_addr = 16'd1;
        lat = 1; st = 1'b1;
        while (!b2.wb_valid && lat < 30) begin
            if (b2.req_ready !== 1'b0) st = 1'b0;
            step(); lat++;
        end
        d = b2.wb_data; t = b2.wb_rd;
        for (int i = 0; i < 4; i++) begin
            step();
            if (b2.wb_valid !== 1'b1 || b2.wb_data !== d || b2.wb_rd !== t ||
                b2.req_ready !== 1'b0 || b2.mem_rd_en !== 1'b0) st = 1'b0;
        end
        b2.wb_ready = 1'b1;
        step();
        b2.wb_ready = 1'b0;
        n_vec++;
        if (lat !== 4 || d !== 16'h4005 || t !== 3'd6) begin
            n_err++; $display("FAIL w2_load5: lat=%0d data=%h tag=%0d want 4 4005 6", lat, d, t);
        end
        n_vec++;
        if (rd2_cnt - rd_s !== 3 || st !== 1'b1 || b2.req_ready !== 1'b1) begin
            n_err++; $display("FAIL w2_load5_hold: rdcyc=%0d stable=%b ready=%b want 3 1 1",
                              rd2_cnt - rd_s, st, b2.req_ready);
        end
        wr_s = wr2_cnt;
        b2.req_we = 1'b1; b2.req_addr = 16'd6; b2.req_wdata = 16'hC0DE; b2.req_valid = 1'b1;
        step();
        b2.req_valid = 1'b0;
        lat = 1;
        while (!b2.req_ready && lat < 30) begin step(); lat++; end
        n_vec++;
        if (lat !== 4 || wr2_cnt - wr_s !== 1 || mem2[6] !== 16'hC0DE) begin
            n_err++; $display("FAIL w2_store6: lat=%0d wr=%0d mem=%h want 4 1 c0de", lat, wr2_cnt - wr_s, mem2[6]);
        end
    endtask

    task automatic test_reset_midop();
        int wr_s;
        wr_s = wr2_cnt;
        b0.wb_ready = 1'b0; b2.wb_ready = 1'b0;
        b0.req_we = 1'b0; b0.req_addr = 16'd2; b0.req_rd = 3'd4; b0.req_valid = 1'b1;
        b2.req_we = 1'b1; b2.req_addr = 16'd7; b2.req_wdata = 16'hDEAD; b2.req_valid = 1'b1;
        step();
        b0.req_valid = 1'b0; b2.req_valid = 1'b0;
        step();
        n_vec++;
        if (b0.wb_valid !== 1'b1 || b2.busy !== 1'b1 || b2.mem_wr_en !== 1'b0) begin
            n_err++; $display("FAIL midop_setup: wbv0=%b busy2=%b wr2=%b want 1 1 0", b0.wb_valid, b2.busy, b2.mem_wr_en);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({b0.wb_valid, b0.req_ready, b2.busy, b2.req_ready, b2.mem_wr_en, b2.mem_rd_en} !== 6'b010100 ||
            b0.wb_data !== 16'h0 || b2.mem_addr !== 16'h0 || b0.fault_count !== 8'h0) begin
            n_err++;
            $display("FAIL midop_async: ctrl=%b wbd0=%h maddr2=%h cnt=%0h want 010100 0 0 0",
                     {b0.wb_valid, b0.req_ready, b2.busy, b2.req_ready, b2.mem_wr_en, b2.mem_rd_en},
                     b0.wb_data, b2.mem_addr, b0.fault_count);
        end
        step(); step();
        rst = 1'b0;
        step(); step();
        m_fcnt = 8'h0; m_faddr = 16'h0;
        n_vec++;
        if (wr2_cnt - wr_s !== 0 || mem2[7] !== 16'h4007 || b2.req_ready !== 1'b1) begin
            n_err++; $display("FAIL midop_dropped: wr=%0d mem7=%h ready=%b want 0 4007 1", wr2_cnt - wr_s, mem2[7], b2.req_ready);
        end
    endtask

    task automatic test_random();
        int lat, nwr, nrd, nflt, e_wr, e_rd, e_flt; logic [15:0] d, a, w; logic [2:0] t, r;
        logic st, we, keep; int hold;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: a = 16'd10;
                1: a = 16'hFFFF;
                2: a = 16'($urandom_range(11, 65534));
                default: a = 16'($urandom_range(0, 9));
            endcase
            we = 1'($urandom_range(0, 1)); w = 16'($urandom); r = 3'($urandom);
            hold = $urandom_range(0, 3); keep = 1'($urandom_range(0, 1));
            run_op0(we, a, w, r, hold, keep, lat, d, t, nwr, nrd, nflt, st);
            e_wr = 0; e_rd = 0; e_flt = 0;
            if (a < 16'd10) begin
                if (we) begin
                    e_wr = 1; ref0[a[3:0]] = w;
                end else begin
                    e_rd = 1;
                    n_vec++;
                    if (d !== ref0[a[3:0]] || t !== r || st !== 1'b1) begin
                        n_err++; $display("FAIL rnd%0d_load: addr=%0d got %h/%0d stable=%b want %h/%0d",
                                          i, a, d, t, st, ref0[a[3:0]], r);
                    end
                end
            end else begin
                e_flt = 1; m_faddr = a;
                if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
            end
            n_vec++;
            if (lat !== 2 || nwr !== e_wr || nrd !== e_rd || nflt !== e_flt ||
                b0.fault_count !== m_fcnt || b0.fault_addr !== m_faddr) begin
                n_err++;
                $display("FAIL rnd%0d_op: lat=%0d wr=%0d rd=%0d flt=%0d cnt=%0d faddr=%h want 2 %0d %0d %0d %0d %h",
                         i, lat, nwr, nrd, nflt, b0.fault_count, b0.fault_addr, e_wr, e_rd, e_flt, m_fcnt, m_faddr);
            end
        end
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (mem0[k] !== ref0[k]) begin
                n_err++; $display("FAIL mem_final%0d: got %h want %h", k, mem0[k], ref0[k]);
            end
        end
        n_vec++;
        if (both_cnt !== 0 || fstrobe_cnt !== 0) begin
            n_err++; $display("FAIL strobe_exclusive: both=%0d fault_strobe=%0d want 0 0", both_cnt, fstrobe_cnt);
        end
    endtask

    initial begin
        for (int k = 0; k < 10; k++) ref0[k] = 16'h4000 + 16'(k);
        m_fcnt = 8'h0; m_faddr = 16'h0;
        rst = 1'b1;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 16'h0; b0.req_wdata = 16'h0;
        b0.req_rd = 3'd0; b0.wb_ready = 1'b0;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 16'h0; b2.req_wdata = 16'h0;
        b2.req_rd = 3'd0; b2.wb_ready = 1'b0;
        test_reset();
        test_load_basic();
        test_store_load();
        test_fault();
        test_fault_saturate();
        test_wait_states();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
